// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_t : receiver FSM states
//   PAR_EVEN / PAR_ODD : parity-type encodings for par_typ
//   DATA_W     : frame data width
//   majority3  : 2-of-3 vote used for oversampled bit decisions
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter, 3-sample majority
// voter and the decision strobe.
//   clk, rst  : receiver clock, synchronous active-high reset
//   rx_s      : synchronized serial line
//   start     : start-bit detection pulse from the FSM (restarts the counter)
//   run       : FSM is inside a frame
//   tick      : decision strobe, high at edge_cnt = PRESCALE/2+1 while running
//   bit_val   : majority of the three mid-bit samples, valid with tick
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_s,
    input  logic start,
    input  logic run,
    output logic tick,
    output logic bit_val
);

    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(PRESCALE / 2);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(PRESCALE / 2 + 1);
    // The line was already low for one synchronized sample before the FSM
    // saw it, so the detection edge is the second edge of the start bit.
    // Loading 2 keeps every bit's decision centred on its own bit window.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(2);

    logic [CNT_W-1:0] edge_cnt;
    logic [1:0]       early;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            early    <= 2'b00;
        end else begin
            if (start) begin
                edge_cnt <= CNT_LOAD;
            end else if (run) begin
                edge_cnt <= (edge_cnt == CNT_LAST) ? '0 : edge_cnt + CNT_W'(1);
            end else begin
                edge_cnt <= '0;
            end

            if (run && edge_cnt == CNT_S0) early[0] <= rx_s;
            if (run && edge_cnt == CNT_S1) early[1] <= rx_s;
        end
    end

    // Third sample is the live value at the decision edge.
    assign tick    = run && (edge_cnt == CNT_S2);
    assign bit_val = majority3({rx_s, early});

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8-bit LSB-first frames with optional parity.
//   clk, rst   : receiver clock (PRESCALE x bit rate), synchronous active-high reset
//   rx_in      : asynchronous serial line, idles high
//   par_en     : parity bit present (captured at start detection)
//   par_typ    : 0 even / 1 odd parity (captured with par_en)
//   p_data     : last good byte
//   data_valid : one-cycle strobe, p_data holds a new good byte
//   par_err    : one-cycle strobe, parity mismatch
//   stp_err    : one-cycle strobe, stop bit sampled low
//
// state  | meaning
// IDLE   | wait for low line while armed
// START  | verify start bit at mid-bit, drop false starts
// DATA   | shift in 8 data bits, LSB first
// PARITY | check received parity bit
// STOP   | check stop bit, issue frame result
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
);

    rx_state_t         state, state_nxt;
    logic              sync1, rx_s;
    logic [1:0]        fill;
    logic              armed;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_en_q, par_typ_q;
    logic              par_bad;
    logic              par_exp;
    logic              start_det;
    logic              run;
    logic              tick;
    logic              bit_val;
    logic              stop_tick;

    assign run       = (state != IDLE);
    assign stop_tick = tick && (state == STOP);

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx_s    (rx_s),
        .start   (start_det),
        .run     (run),
        .tick    (tick),
        .bit_val (bit_val)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) state_nxt = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (tick && bit_cnt == 3'(DATA_W - 1))
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        par_exp = 1'b0;
        case (par_typ_q)
            PAR_EVEN: par_exp = ^shift_reg;
            PAR_ODD:  par_exp = ~^shift_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            fill       <= 2'b00;
            armed      <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            sync1      <= rx_in;
            rx_s       <= sync1;
            fill       <= {fill[0], 1'b1};
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            // rx_s only reflects the real line once both synchronizer flops
            // have reloaded after reset; arming on the reset value of 1 would
            // let a line held low through reset look like a start bit.
            if (stop_tick && !bit_val)  armed <= 1'b0;
            else if (fill[1] && rx_s)   armed <= 1'b1;

            if (start_det) begin
                bit_cnt   <= '0;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_bad   <= 1'b0;
            end

            if (tick && state == DATA) begin
                shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end

            if (tick && state == PARITY) par_bad <= (bit_val != par_exp);

            if (stop_tick) begin
                if (!par_bad && bit_val) begin
                    p_data     <= shift_reg;
                    data_valid <= 1'b1;
                end
                par_err <= par_bad;
                stp_err <= !bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at PRESCALE = 8.
module tb_uart_rx;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int n_dv = 0, n_pe = 0, n_se = 0, n_both = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_bytes[$];
    int b_dv, b_pe, b_se;
    int t0, t0b;

    uart_rx #(
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            n_dv++;
            dv_cyc = cyc;
            dv_bytes.push_back(p_data);
        end
        if (par_err) begin
            n_pe++;
            pe_cyc = cyc;
        end
        if (stp_err) begin
            n_se++;
            se_cyc = cyc;
        end
        if (data_valid && (par_err || stp_err)) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < dv_bytes.size()) return dv_bytes[i];
        return 8'hxx;
    endfunction

    task automatic snap();
        b_dv = n_dv;
        b_pe = n_pe;
        b_se = n_se;
    endtask

    task automatic drive_line(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = v;
        end
    endtask

    // Drives one frame, P cycles per bit. glitch inverts each data bit at one
    // of its three sample offsets (P/2-2 .. P/2), rotating bit to bit.
    task automatic send(input logic [7:0] d, input bit par_on, input bit par_bit,
                        input bit stop_bit, input bit glitch, output int t_start);
        logic [10:0] bits;
        int          nb;
        logic        v;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (par_on) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            nb       = 11;
        end else begin
            bits[9]  = stop_bit;
            nb       = 10;
        end
        t_start = 0;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < P; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) t_start = cyc + 1;
                v = bits[k];
                if (glitch && k >= 1 && k <= 8 && c == P/2 - 2 + ((k - 1) % 3)) v = ~v;
                rx_in = v;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_in   = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_p_data", 32'(p_data), 32'h00);
        chk("rst_dv",     32'(data_valid), 32'd0);
        chk("rst_pe",     32'(par_err), 32'd0);
        chk("rst_se",     32'(stp_err), 32'd0);
        rst = 1'b0;
        drive_line(1'b1, 10);

        // plain frame, no parity
        snap();
        send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("a5_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("a5_lat",    32'(dv_cyc - t0), 32'd78);
        chk("a5_byte",   32'(byte_at(b_dv)), 32'hA5);
        chk("a5_p_data", 32'(p_data), 32'hA5);
        chk("a5_errs",   32'((n_pe - b_pe) + (n_se - b_se)), 32'd0);

        // even parity, correct parity bit
        par_en  = 1'b1;
        par_typ = 1'b0;
        snap();
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("par_ok_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("par_ok_lat",    32'(dv_cyc - t0), 32'd86);
        chk("par_ok_p_data", 32'(p_data), 32'h3C);
        chk("par_ok_errs",   32'((n_pe - b_pe) + (n_se - b_se)), 32'd0);

        // even parity, wrong parity bit
        snap();
        send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("par_bad_pe_cnt", 32'(n_pe - b_pe), 32'd1);
        chk("par_bad_lat",    32'(pe_cyc - t0), 32'd86);
        chk("par_bad_dv_cnt", 32'(n_dv - b_dv), 32'd0);
        chk("par_bad_se_cnt", 32'(n_se - b_se), 32'd0);
        chk("par_bad_p_data", 32'(p_data), 32'h3C);

        // stop bit low, line held low afterwards
        par_en = 1'b0;
        snap();
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        drive_line(1'b0, 30);
        chk("stp_se_cnt", 32'(n_se - b_se), 32'd1);
        chk("stp_lat",    32'(se_cyc - t0), 32'd78);
        chk("stp_dv_cnt", 32'(n_dv - b_dv), 32'd0);
        chk("stp_pe_cnt", 32'(n_pe - b_pe), 32'd0);
        chk("stp_p_data", 32'(p_data), 32'h3C);
        drive_line(1'b1, 8);
        send(8'h42, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("after_stp_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("after_stp_p_data", 32'(p_data), 32'h42);
        chk("after_stp_se_cnt", 32'(n_se - b_se), 32'd1);

        // false start: two low cycles
        snap();
        drive_line(1'b0, 2);
        drive_line(1'b1, 20);
        chk("false_strobes", 32'((n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se)), 32'd0);
        send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("false_next_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("false_next_lat",    32'(dv_cyc - t0), 32'd78);
        chk("false_next_p_data", 32'(p_data), 32'h55);

        // single-sample glitches on every data bit
        snap();
        send(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        drive_line(1'b1, 6);
        chk("glitch_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("glitch_p_data", 32'(p_data), 32'hF0);
        chk("glitch_errs",   32'((n_pe - b_pe) + (n_se - b_se)), 32'd0);

        // back-to-back frames, stop bit exactly P cycles
        snap();
        send(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        send(8'h34, 1'b0, 1'b0, 1'b1, 1'b0, t0b);
        drive_line(1'b1, 6);
        chk("b2b_dv_cnt", 32'(n_dv - b_dv), 32'd2);
        chk("b2b_byte0",  32'(byte_at(b_dv)), 32'h12);
        chk("b2b_byte1",  32'(byte_at(b_dv + 1)), 32'h34);
        chk("b2b_lat1",   32'(dv_cyc - t0b), 32'd78);
        chk("b2b_errs",   32'((n_pe - b_pe) + (n_se - b_se)), 32'd0);

        // reset in the middle of a frame with the line low
        snap();
        drive_line(1'b0, 30);
        @(negedge clk);
        rst = 1'b1;
        drive_line(1'b0, 3);
        rst = 1'b0;
        drive_line(1'b0, 40);
        chk("rst_mid_strobes", 32'((n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se)), 32'd0);
        chk("rst_mid_p_data",  32'(p_data), 32'h00);
        drive_line(1'b1, 6);
        send(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        drive_line(1'b1, 6);
        chk("rst_mid_next_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        chk("rst_mid_next_p_data", 32'(p_data), 32'h99);
        chk("rst_mid_next_errs",   32'((n_pe - b_pe) + (n_se - b_se)), 32'd0);

        chk("strobe_exclusive", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
